// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle ARM-subset controller.
// Covers FSM states, instruction field encodings, ALU op codes and per-state control outputs.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXER,
        S_EXEI,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } ctrl_t;

    function automatic state_t next_state(state_t s, logic [1:0] op, logic imm, logic load);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:   n = imm ? S_EXEI : S_EXER;
                    OP_MEM:  n = S_MEMADR;
                    OP_BR:   n = S_BRANCH;
                    default: n = S_FETCH;
                endcase
            end
            S_EXER, S_EXEI: n = S_ALUWB;
            S_MEMADR:       n = load ? S_MEMRD : S_MEMWR;
            S_MEMRD:        n = S_MEMWB;
            default:        n = S_FETCH;
        endcase
        return n;
    endfunction

    // gate is the condition result that applies while in state s.
    function automatic ctrl_t ctrl_for(state_t s, logic gate, logic rd_is_pc, logic dp_wr,
                                       logic [1:0] dp_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_EXER: c.alu_control = dp_alu;
            S_EXEI: begin
                c.alu_src_b   = 2'b01;
                c.alu_control = dp_alu;
            end
            S_ALUWB: begin
                c.reg_write = gate & dp_wr & ~rd_is_pc;
                c.pc_write  = gate & dp_wr & rd_is_pc;
            end
            S_MEMADR: begin
                c.alu_src_b   = 2'b01;
                c.imm_src     = 2'b01;
                c.alu_control = ALU_ADD;
            end
            S_MEMRD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = gate & ~rd_is_pc;
                c.pc_write   = gate & rd_is_pc;
            end
            S_MEMWR: begin
                c.adr_src   = 1'b1;
                c.mem_write = gate;
                c.reg_src   = 2'b10;
            end
            S_BRANCH: begin
                c.reg_src    = 2'b01;
                c.alu_src_b  = 2'b01;
                c.imm_src    = 2'b10;
                c.result_src = 2'b10;
                c.pc_write   = gate;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition-code evaluation: 4-bit cond field against NZCV flags.
// Purely combinational; cond 4'hF never executes.
module multicycle_controller_cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_condex
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_condex = 1'b0;
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = (w_n == w_v);
            COND_LT: o_condex = (w_n != w_v);
            COND_GT: o_condex = ~w_z & (w_n == w_v);
            COND_LE: o_condex = w_z | (w_n != w_v);
            COND_AL: o_condex = 1'b1;
            default: o_condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle controller: instruction decode, sequencing FSM, NZCV register and condition gating.
// Control outputs are registered alongside the state, so each output reflects the current state.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter logic [3:0] PC_REG   = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags
);

    state_t     r_state;
    ctrl_t      r_ctrl;
    logic [3:0] r_flags;
    logic       r_condex_q;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_condex;
    logic       w_gate;
    logic [1:0] w_dp_alu;
    logic       w_dp_wr;
    logic       w_dp_s;
    logic       w_dp_nzcv_all;
    logic       w_unused_instr;

    assign w_cond         = instr[31:28];
    assign w_op           = instr[27:26];
    assign w_funct        = instr[25:20];
    assign w_rd           = instr[15:12];
    assign w_unused_instr = &{1'b0, instr[19:16], instr[11:0]};

    always_comb begin
        w_dp_alu      = ALU_ADD;
        w_dp_wr       = 1'b1;
        w_dp_s        = w_funct[0];
        w_dp_nzcv_all = 1'b1;
        case (w_funct[4:1])
            CMD_ADD: w_dp_alu = ALU_ADD;
            CMD_SUB: w_dp_alu = ALU_SUB;
            CMD_AND: begin
                w_dp_alu      = ALU_AND;
                w_dp_nzcv_all = 1'b0;
            end
            CMD_ORR: begin
                w_dp_alu      = ALU_ORR;
                w_dp_nzcv_all = 1'b0;
            end
            CMD_CMP: begin
                w_dp_alu = ALU_SUB;
                w_dp_wr  = 1'b0;
                w_dp_s   = 1'b1;
            end
            default: w_dp_wr = 1'b0;
        endcase
    end

    multicycle_controller_cond_check u_cond_check (
        .i_cond   (w_cond),
        .i_nzcv   (r_flags),
        .o_condex (w_condex)
    );

    // Leaving DECODE, condex_q is not yet loaded, so the live result gates the next state.
    assign w_gate = (r_state == S_DECODE) ? w_condex : r_condex_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_ctrl     <= ctrl_for(S_FETCH, 1'b0, 1'b0, 1'b0, ALU_ADD);
            r_flags    <= FLAG_RST;
            r_condex_q <= 1'b0;
        end else begin
            r_state <= next_state(r_state, w_op, w_funct[5], w_funct[0]);
            r_ctrl  <= ctrl_for(next_state(r_state, w_op, w_funct[5], w_funct[0]),
                                w_gate, (w_rd == PC_REG), w_dp_wr, w_dp_alu);
            if (r_state == S_DECODE) begin
                r_condex_q <= w_condex;
            end
            if ((r_state == S_EXER || r_state == S_EXEI) && r_condex_q && w_dp_s) begin
                r_flags[3:2] <= alu_flags[3:2];
                if (w_dp_nzcv_all) begin
                    r_flags[1:0] <= alu_flags[1:0];
                end
            end
        end
    end

    assign pc_write    = r_ctrl.pc_write;
    assign adr_src     = r_ctrl.adr_src;
    assign mem_write   = r_ctrl.mem_write;
    assign ir_write    = r_ctrl.ir_write;
    assign reg_write   = r_ctrl.reg_write;
    assign alu_src_a   = r_ctrl.alu_src_a;
    assign alu_src_b   = r_ctrl.alu_src_b;
    assign result_src  = r_ctrl.result_src;
    assign alu_control = r_ctrl.alu_control;
    assign imm_src     = r_ctrl.imm_src;
    assign reg_src     = r_ctrl.reg_src;
    assign flags       = r_flags;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control signatures and flag register.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, result_src, alu_control, imm_src, reg_src;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    // Signature layout: ir,pc,rw,mw,adr,srcA,srcB[2],res[2],aluctl[2],imm[2],regsrc[2]
    localparam logic [15:0] SG_FETCH    = 16'b1_1_0_0_0_1_10_10_00_00_00;
    localparam logic [15:0] SG_DECODE   = 16'b0_0_0_0_0_1_10_00_00_00_00;
    localparam logic [15:0] SG_EXER_ADD = 16'b0_0_0_0_0_0_00_00_00_00_00;
    localparam logic [15:0] SG_EXEI_ADD = 16'b0_0_0_0_0_0_01_00_00_00_00;
    localparam logic [15:0] SG_EXEI_SUB = 16'b0_0_0_0_0_0_01_00_01_00_00;
    localparam logic [15:0] SG_EXEI_AND = 16'b0_0_0_0_0_0_01_00_10_00_00;
    localparam logic [15:0] SG_EXEI_ORR = 16'b0_0_0_0_0_0_01_00_11_00_00;
    localparam logic [15:0] SG_WB_REG   = 16'b0_0_1_0_0_0_00_00_00_00_00;
    localparam logic [15:0] SG_WB_PC    = 16'b0_1_0_0_0_0_00_00_00_00_00;
    localparam logic [15:0] SG_WB_NONE  = 16'b0_0_0_0_0_0_00_00_00_00_00;
    localparam logic [15:0] SG_MEMADR   = 16'b0_0_0_0_0_0_01_00_00_01_00;
    localparam logic [15:0] SG_MEMWR_N  = 16'b0_0_0_0_1_0_00_00_00_00_10;
    localparam logic [15:0] SG_MEMWR_T  = 16'b0_0_0_1_1_0_00_00_00_00_10;
    localparam logic [15:0] SG_MEMRD    = 16'b0_0_0_0_1_0_00_00_00_00_00;
    localparam logic [15:0] SG_MEMWB_PC = 16'b0_1_0_0_0_0_00_01_00_00_00;
    localparam logic [15:0] SG_BR_T     = 16'b0_1_0_0_0_0_01_10_00_10_01;
    localparam logic [15:0] SG_BR_N     = 16'b0_0_0_0_0_0_01_10_00_10_01;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] sig();
        return {ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
                alu_src_b, result_src, alu_control, imm_src, reg_src};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction through n cycles without checking; used to set up flags.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int n);
        instr     = ins;
        alu_flags = af;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        instr     = 32'hE2811005;
        alu_flags = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (sig() !== SG_FETCH) begin
            n_err++;
            $display("FAIL reset_sig got=%b want=%b", sig(), SG_FETCH);
        end
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=0000", flags);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] seq [5] = '{SG_FETCH, SG_DECODE, SG_EXEI_ADD, SG_WB_REG, SG_FETCH};
        instr     = 32'hE2811005;
        alu_flags = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (sig() !== seq[i]) begin
                n_err++;
                $display("FAIL add_cyc%0d got=%b want=%b", i, sig(), seq[i]);
            end
            if (i < 4) step();
        end
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL add_noS_flags got=%b want=0000", flags);
        end
    endtask

    task automatic test_branch();
        logic [15:0] sub_seq [4] = '{SG_FETCH, SG_DECODE, SG_EXEI_SUB, SG_WB_REG};
        logic [15:0] beq_seq [4] = '{SG_FETCH, SG_DECODE, SG_BR_T, SG_FETCH};
        logic [15:0] bne_seq [4] = '{SG_FETCH, SG_DECODE, SG_BR_N, SG_FETCH};
        instr     = 32'hE2500000;
        alu_flags = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== sub_seq[i]) begin
                n_err++;
                $display("FAIL subs_cyc%0d got=%b want=%b", i, sig(), sub_seq[i]);
            end
            step();
        end
        n_vec++;
        if (flags !== 4'b0100) begin
            n_err++;
            $display("FAIL subs_flags got=%b want=0100", flags);
        end
        instr     = 32'h0A000002;
        alu_flags = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== beq_seq[i]) begin
                n_err++;
                $display("FAIL beq_cyc%0d got=%b want=%b", i, sig(), beq_seq[i]);
            end
            if (i < 3) step();
        end
        instr = 32'h1A000002;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== bne_seq[i]) begin
                n_err++;
                $display("FAIL bne_cyc%0d got=%b want=%b", i, sig(), bne_seq[i]);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_ands();
        run_instr(32'hE2500000, 4'b0011, 4);
        n_vec++;
        if (flags !== 4'b0011) begin
            n_err++;
            $display("FAIL ands_setup_flags got=%b want=0011", flags);
        end
        instr     = 32'hE2100000;
        alu_flags = 4'b1011;
        step();
        step();
        n_vec++;
        if (sig() !== SG_EXEI_AND) begin
            n_err++;
            $display("FAIL ands_exe got=%b want=%b", sig(), SG_EXEI_AND);
        end
        step();
        step();
        n_vec++;
        if (flags !== 4'b1011) begin
            n_err++;
            $display("FAIL ands_flags1 got=%b want=1011", flags);
        end
        run_instr(32'hE2500000, 4'b0011, 4);
        run_instr(32'hE2100000, 4'b1100, 4);
        n_vec++;
        if (flags !== 4'b1111) begin
            n_err++;
            $display("FAIL ands_cv_held got=%b want=1111", flags);
        end
    endtask

    task automatic test_str();
        logic [15:0] seq_n [5] = '{SG_FETCH, SG_DECODE, SG_MEMADR, SG_MEMWR_N, SG_FETCH};
        logic [15:0] seq_t [5] = '{SG_FETCH, SG_DECODE, SG_MEMADR, SG_MEMWR_T, SG_FETCH};
        run_instr(32'hE2500000, 4'b0000, 4);
        instr = 32'h05812000;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (sig() !== seq_n[i]) begin
                n_err++;
                $display("FAIL streq_z0_cyc%0d got=%b want=%b", i, sig(), seq_n[i]);
            end
            if (i < 4) step();
        end
        run_instr(32'hE2500000, 4'b0100, 4);
        instr = 32'h05812000;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (sig() !== seq_t[i]) begin
                n_err++;
                $display("FAIL streq_z1_cyc%0d got=%b want=%b", i, sig(), seq_t[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_ldr_pc();
        logic [15:0] seq [6] = '{SG_FETCH, SG_DECODE, SG_MEMADR, SG_MEMRD, SG_MEMWB_PC, SG_FETCH};
        instr = 32'hE591F000;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (sig() !== seq[i]) begin
                n_err++;
                $display("FAIL ldr_pc_cyc%0d got=%b want=%b", i, sig(), seq[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_reset_mid();
        instr     = 32'hE2911005;
        alu_flags = 4'b1111;
        step();
        step();
        n_vec++;
        if (sig() !== SG_EXEI_ADD) begin
            n_err++;
            $display("FAIL rstmid_exe got=%b want=%b", sig(), SG_EXEI_ADD);
        end
        rst_n = 1'b0;
        step();
        n_vec++;
        if (sig() !== SG_FETCH) begin
            n_err++;
            $display("FAIL rstmid_sig got=%b want=%b", sig(), SG_FETCH);
        end
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_flags got=%b want=0000", flags);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_misc();
        logic [15:0] ill_seq [3] = '{SG_FETCH, SG_DECODE, SG_FETCH};
        logic [15:0] pc_seq  [4] = '{SG_FETCH, SG_DECODE, SG_EXEI_ADD, SG_WB_PC};
        logic [15:0] cmp_seq [4] = '{SG_FETCH, SG_DECODE, SG_EXEI_SUB, SG_WB_NONE};
        logic [15:0] ne_seq  [4] = '{SG_FETCH, SG_DECODE, SG_EXEI_ADD, SG_WB_NONE};
        logic [15:0] orr_seq [4] = '{SG_FETCH, SG_DECODE, SG_EXEI_ORR, SG_WB_REG};
        logic [15:0] exr_seq [4] = '{SG_FETCH, SG_DECODE, SG_EXER_ADD, SG_WB_REG};
        instr     = 32'hEC000000;
        alu_flags = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (sig() !== ill_seq[i]) begin
                n_err++;
                $display("FAIL illegal_cyc%0d got=%b want=%b", i, sig(), ill_seq[i]);
            end
            if (i < 2) step();
        end
        instr = 32'hE281F005;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== pc_seq[i]) begin
                n_err++;
                $display("FAIL add_pc_cyc%0d got=%b want=%b", i, sig(), pc_seq[i]);
            end
            step();
        end
        instr     = 32'hE3500000;
        alu_flags = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== cmp_seq[i]) begin
                n_err++;
                $display("FAIL cmp_cyc%0d got=%b want=%b", i, sig(), cmp_seq[i]);
            end
            step();
        end
        n_vec++;
        if (flags !== 4'b0110) begin
            n_err++;
            $display("FAIL cmp_flags got=%b want=0110", flags);
        end
        instr     = 32'h12911005;
        alu_flags = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== ne_seq[i]) begin
                n_err++;
                $display("FAIL addsne_cyc%0d got=%b want=%b", i, sig(), ne_seq[i]);
            end
            step();
        end
        n_vec++;
        if (flags !== 4'b0110) begin
            n_err++;
            $display("FAIL addsne_flags got=%b want=0110", flags);
        end
        instr = 32'hE3800000;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== orr_seq[i]) begin
                n_err++;
                $display("FAIL orr_cyc%0d got=%b want=%b", i, sig(), orr_seq[i]);
            end
            step();
        end
        instr = 32'hE0811002;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sig() !== exr_seq[i]) begin
                n_err++;
                $display("FAIL add_reg_cyc%0d got=%b want=%b", i, sig(), exr_seq[i]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_ands();
        test_str();
        test_ldr_pc();
        test_reset_mid();
        test_misc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
